// File: rtl/iccm_ctrl_pkg.sv
// Shared types and constants for the ICCM load arbiter: FSM state encoding,
// default bus widths and read-error codes.
package iccm_ctrl_pkg;

  localparam int ICCM_AW = 11;
  localparam int ICCM_DW = 32;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_RUN     = 2'd2,
    ST_QUIESCE = 2'd3
  } iccm_state_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_UNCORR = 2'b10;

endpackage

// File: rtl/iccm_ctrl_fsm.sv
// Ownership FSM for the ICCM port: loader owns it in LOAD, core owns it in RUN,
// DRAIN and QUIESCE are the hand-over states in each direction.
module iccm_ctrl_fsm
  import iccm_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_ld_done,
  input  logic        i_reload_req,
  input  logic        i_rd_pending,
  output iccm_state_e o_state,
  output logic        o_enter_load
);

  iccm_state_e r_state;
  iccm_state_e w_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    o_enter_load = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (i_ld_done) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_reload_req) w_next = ST_QUIESCE;
      end
      ST_QUIESCE: begin
        // Loader may only take the port back once every granted read has returned.
        if (!i_rd_pending) begin
          w_next       = ST_LOAD;
          o_enter_load = 1'b1;
        end
      end
      default: begin
        w_next = ST_LOAD;
      end
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/iccm_load_arbiter.sv
// Arbitrates the ICCM SRAM port between the program loader and the core.
// Optional macro ICCM_CORE_WRITE_PROTECT_EN blocks core writes and flags them on core_err_o.
module iccm_load_arbiter
  import iccm_ctrl_pkg::*;
#(
  parameter int AW = ICCM_AW,
  parameter int DW = ICCM_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          ld_valid_i,
  output logic          ld_ready_o,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_wdata_i,
  input  logic [DW-1:0] ld_wmask_i,
  input  logic          ld_done_i,
  input  logic          reload_req_i,

  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  input  logic [DW-1:0] core_wmask_i,
  output logic          core_gnt_o,
  output logic [DW-1:0] core_rdata_o,
  output logic          core_rvalid_o,
  output logic [1:0]    core_err_o,

  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [DW-1:0] mem_wmask_o,
  input  logic [DW-1:0] mem_rdata_i,

  output logic [1:0]    state_o,
  output logic [AW:0]   load_count_o,
  output logic          core_fetch_en_o
);

  localparam logic [AW:0] LP_CNT_MAX = {1'b1, {AW{1'b0}}};

  iccm_state_e w_state;
  logic        w_enter_load;
  logic        w_in_load;
  logic        w_in_run;
  logic        w_ld_acc;
  logic        w_core_gnt;
  logic        w_core_fwd;
  logic        r_rvalid;
  logic [AW:0] r_load_count;

  iccm_ctrl_fsm u_fsm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_ld_done    (ld_done_i),
    .i_reload_req (reload_req_i),
    .i_rd_pending (r_rvalid),
    .o_state      (w_state),
    .o_enter_load (w_enter_load)
  );

  // Reset gates the loader path directly so no write escapes while rst_i is high.
  assign w_in_load  = (w_state == ST_LOAD) & ~rst_i;
  assign w_in_run   = (w_state == ST_RUN) & ~reload_req_i;
  assign w_ld_acc   = w_in_load & ld_valid_i;
  assign w_core_gnt = w_in_run & core_req_i;

`ifdef ICCM_CORE_WRITE_PROTECT_EN
  logic r_werr;

  assign w_core_fwd = w_core_gnt & ~core_we_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_werr <= 1'b0;
    end else begin
      r_werr <= w_core_gnt & core_we_i;
    end
  end

  assign core_err_o = r_werr ? ERR_UNCORR : ERR_NONE;
`else
  assign w_core_fwd = w_core_gnt;
  assign core_err_o = ERR_NONE;
`endif

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (w_ld_acc) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = ld_addr_i;
      mem_wdata_o = ld_wdata_i;
      mem_wmask_o = ld_wmask_i;
    end else if (w_core_fwd) begin
      mem_en_o    = 1'b1;
      mem_we_o    = core_we_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
      mem_wmask_o = core_wmask_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid     <= 1'b0;
      r_load_count <= '0;
    end else begin
      r_rvalid <= w_core_gnt & ~core_we_i;
      if (w_enter_load) begin
        r_load_count <= '0;
      end else if (w_ld_acc && (r_load_count != LP_CNT_MAX)) begin
        r_load_count <= r_load_count + 1'b1;
      end
    end
  end

  assign ld_ready_o      = w_in_load;
  assign core_gnt_o      = w_core_gnt;
  assign core_fetch_en_o = w_in_run;
  assign core_rvalid_o   = r_rvalid;
  assign core_rdata_o    = mem_rdata_i;
  assign state_o         = w_state;
  assign load_count_o    = r_load_count;

endmodule

// File: tb/tb_iccm_load_arbiter.sv
// Bench for iccm_load_arbiter: directed scenarios plus random traffic, checked every
// cycle against a behavioural ownership/memory model.
module tb_iccm_load_arbiter;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int NW   = 1 << AW;
  localparam int CMAX = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          ld_valid_i = 1'b0;
  logic          ld_ready_o;
  logic [AW-1:0] ld_addr_i = '0;
  logic [DW-1:0] ld_wdata_i = '0;
  logic [DW-1:0] ld_wmask_i = '0;
  logic          ld_done_i = 1'b0;
  logic          reload_req_i = 1'b0;
  logic          core_req_i = 1'b0;
  logic          core_we_i = 1'b0;
  logic [AW-1:0] core_addr_i = '0;
  logic [DW-1:0] core_wdata_i = '0;
  logic [DW-1:0] core_wmask_i = '0;
  logic          core_gnt_o;
  logic [DW-1:0] core_rdata_o;
  logic          core_rvalid_o;
  logic [1:0]    core_err_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_wmask_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic [1:0]    state_o;
  logic [AW:0]   load_count_o;
  logic          core_fetch_en_o;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

`ifdef ICCM_CORE_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  iccm_load_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_addr_i(ld_addr_i),
    .ld_wdata_i(ld_wdata_i), .ld_wmask_i(ld_wmask_i), .ld_done_i(ld_done_i),
    .reload_req_i(reload_req_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_wmask_i(core_wmask_i), .core_gnt_o(core_gnt_o),
    .core_rdata_o(core_rdata_o), .core_rvalid_o(core_rvalid_o), .core_err_o(core_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i),
    .state_o(state_o), .load_count_o(load_count_o), .core_fetch_en_o(core_fetch_en_o)
  );

  always #5 clk_i = ~clk_i;

  // External SRAM seen by the DUT.
  logic [DW-1:0] sram [NW];
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) sram[mem_addr_o] <= (sram[mem_addr_o] & ~mem_wmask_o) | (mem_wdata_o & mem_wmask_o);
      else          mem_rdata_i <= sram[mem_addr_o];
    end
  end

  // Behavioural model: who owns the port, what memory must hold, what the core sees.
  int            m_state = 0;
  int            m_cnt   = 0;
  bit            m_rv    = 1'b0;
  bit            m_err   = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] m_mem [NW];

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [DW-1:0] m);
    return (old & ~m) | (d & m);
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_rv    <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      m_rv  <= 1'b0;
      m_err <= 1'b0;
      case (m_state)
        0: begin
          if (ld_valid_i) begin
            m_mem[ld_addr_i] <= merge(m_mem[ld_addr_i], ld_wdata_i, ld_wmask_i);
            m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
          end
          if (ld_done_i) m_state <= 1;
        end
        1: m_state <= 2;
        2: begin
          if (reload_req_i) m_state <= 3;
          else if (core_req_i) begin
            if (!core_we_i) begin
              m_rv    <= 1'b1;
              m_rdata <= m_mem[core_addr_i];
            end else if (PROT) begin
              m_err <= 1'b1;
            end else begin
              m_mem[core_addr_i] <= merge(m_mem[core_addr_i], core_wdata_i, core_wmask_i);
            end
          end
        end
        default: begin
          if (!m_rv) begin
            m_state <= 0;
            m_cnt   <= 0;
          end
        end
      endcase
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    #2;
    if (cmp_en) begin
      bit ld_ok, run_ok, gnt, ld_acc, core_fwd, en, we;
      ld_ok    = (m_state == 0) && !rst_i;
      run_ok   = (m_state == 2) && !reload_req_i;
      gnt      = run_ok && core_req_i;
      ld_acc   = ld_ok && ld_valid_i;
      core_fwd = gnt && !(core_we_i && PROT);
      en       = ld_acc || core_fwd;
      we       = ld_acc ? 1'b1 : (core_fwd && core_we_i);
      check("state", state_o, m_state);
      check("load_count", load_count_o, m_cnt);
      check("ld_ready", ld_ready_o, ld_ok);
      check("core_gnt", core_gnt_o, gnt);
      check("fetch_en", core_fetch_en_o, run_ok);
      check("mem_en", mem_en_o, en);
      check("mem_we", mem_we_o, we);
      if (en) begin
        check("mem_addr",  mem_addr_o,  ld_acc ? ld_addr_i  : core_addr_i);
        check("mem_wdata", mem_wdata_o, ld_acc ? ld_wdata_i : core_wdata_i);
        check("mem_wmask", mem_wmask_o, ld_acc ? ld_wmask_i : core_wmask_i);
      end
      check("rvalid", core_rvalid_o, m_rv);
      if (m_rv) check("rdata", core_rdata_o, m_rdata);
      check("err", core_err_o, m_err ? 2'b10 : 2'b00);
    end
  end

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit done);
    ld_valid_i = 1'b1; ld_addr_i = a; ld_wdata_i = d; ld_wmask_i = '1; ld_done_i = done;
  endtask

  task automatic idle();
    ld_valid_i = 1'b0; ld_done_i = 1'b0; reload_req_i = 1'b0;
    core_req_i = 1'b0; core_we_i = 1'b0;
  endtask

  task automatic core(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req_i = 1'b1; core_we_i = w; core_addr_i = a; core_wdata_i = d; core_wmask_i = '1;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      sram[i]  = '0;
      m_mem[i] = '0;
    end
    #1 rst_i = 1'b1;
    #1 cmp_en = 1'b1;
    step(); step();
    #1;
    check("rst_state", state_o, 0);
    check("rst_count", load_count_o, 0);
    check("rst_mem_en", mem_en_o, 0);

    // Loader beats 0..3; the first one lands in the first cycle after reset drops.
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      beat(AW'(i), 32'hA0 + i, 1'b0);
      #1;
      check("ld_mem_en", mem_en_o, 1);
      check("ld_mem_addr", mem_addr_o, i);
      check("ld_mem_wdata", mem_wdata_o, 32'hA0 + i);
      check("ld_no_gnt", core_gnt_o, 0);
    end
    step(); idle(); #1;
    check("count_4", load_count_o, 4);

    // Last beat coincides with done.
    beat(4'd7, 32'hA7, 1'b1); #1;
    check("done_beat_en", mem_en_o, 1);
    step(); idle(); #1;
    check("drain_state", state_o, 1);
    check("count_5", load_count_o, 5);
    check("drain_no_mem", mem_en_o, 0);
    step(); #1;
    check("run_state", state_o, 2);
    check("run_fetch_en", core_fetch_en_o, 1);

    core(1'b0, 4'd2, '0); #1;
    check("rd2_gnt", core_gnt_o, 1);
    step(); idle(); #1;
    check("rd2_rvalid", core_rvalid_o, 1);
    check("rd2_rdata", core_rdata_o, 32'hA2);

    // Core write to address 1 then read back.
    step(); core(1'b1, 4'd1, 32'hDEADBEEF); #1;
    check("cw_gnt", core_gnt_o, 1);
    check("cw_mem_en", mem_en_o, PROT ? 0 : 1);
    step(); idle(); #1;
    check("cw_err", core_err_o, PROT ? 2'b10 : 2'b00);
    check("cw_no_rvalid", core_rvalid_o, 0);
    step(); core(1'b0, 4'd1, '0);
    step(); idle(); #1;
    check("cw_err_clear", core_err_o, 0);
    check("rd1_rdata", core_rdata_o, PROT ? 32'hA1 : 32'hDEADBEEF);

    // Reset pulse while a read is outstanding.
    step(); core(1'b0, 4'd0, '0);
    @(posedge clk_i); #1;
    rst_i = 1'b1; core_req_i = 1'b0; #1;
    check("rstp_rvalid", core_rvalid_o, 0);
    check("rstp_state", state_o, 0);
    #1 rst_i = 1'b0;
    step(); #1;
    check("rstp_rvalid_after", core_rvalid_o, 0);
    beat(4'd8, 32'h88, 1'b0);
    step(); beat(4'd9, 32'h99, 1'b1);
    step(); idle();
    step(); #1;
    check("run2_state", state_o, 2);

    // Read granted, then reload the next cycle.
    core(1'b0, 4'd3, '0);
    step(); core(1'b0, 4'd4, '0); reload_req_i = 1'b1; #1;
    check("rl_rvalid", core_rvalid_o, 1);
    check("rl_rdata", core_rdata_o, 32'hA3);
    check("rl_gnt", core_gnt_o, 0);
    check("rl_fetch", core_fetch_en_o, 0);
    step(); idle(); #1;
    check("q_state", state_o, 3);
    check("q_count", load_count_o, 2);
    step(); #1;
    check("reload_state", state_o, 0);
    check("reload_count", load_count_o, 0);

    // Saturation of the beat counter.
    for (int i = 0; i < CMAX + 3; i++) begin
      beat(AW'(i), $urandom, 1'b0);
      step();
    end
    idle(); #1;
    check("count_sat", load_count_o, CMAX);

    // Random traffic, checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      step();
      ld_valid_i   = $urandom_range(0, 1);
      ld_addr_i    = AW'($urandom);
      ld_wdata_i   = $urandom;
      ld_wmask_i   = ($urandom_range(0, 3) == 0) ? $urandom : '1;
      ld_done_i    = ($urandom_range(0, 15) == 0);
      reload_req_i = ($urandom_range(0, 23) == 0);
      core_req_i   = $urandom_range(0, 1);
      core_we_i    = ($urandom_range(0, 2) == 0);
      core_addr_i  = AW'($urandom);
      core_wdata_i = $urandom;
      core_wmask_i = ($urandom_range(0, 3) == 0) ? $urandom : '1;
    end
    step(); idle();
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
